fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the CPU, succeeding the fixed single-word fetch inside control_unit. It owns the PC, issues in-order word reads to instruction memory over a valid/ready request channel, and buffers returned words in a DEPTH-entry prefetch queue. It hands instructions to decode over a valid/ready channel, and flushes on branch redirect while discarding stale in-flight responses.

---
 rtl/fetch_prefetch_pkg.sv | 15 +
 rtl/fetch_prefetch_unit_fifo.sv | 65 ++++++
 rtl/fetch_prefetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_pkg.sv
// Shared defaults for the fetch front end; the top-level parameters take their defaults from here.
// Holds the width, depth and reset-PC defaults plus the counter-width helper used by the queue and the credit logic.
package fetch_prefetch_pkg;

  localparam int FETCH_WORD_WIDTH = 32;
  localparam int FETCH_ADDR_WIDTH = 14;
  localparam int FETCH_DEPTH      = 4;
  localparam int FETCH_RESET_PC   = 0;

  // Counters must hold the value DEPTH itself, not just DEPTH-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Synchronous FIFO with flush and occupancy count; the write lands on the clock edge, the read is combinational from the head.
// A push is dropped when the FIFO is full unless a pop happens in the same cycle; a pop on empty is ignored; flush wins over push and pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         nreset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  input  logic                         flush,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order word reads under a DEPTH credit cap, queues responses for decode.
// Memory latency + 1 cycle from request to decode; decode stalls back up through the queue and hold off new requests.
module fetch_prefetch_unit
  import fetch_prefetch_pkg::*;
#(
  parameter int WORD_WIDTH = FETCH_WORD_WIDTH,
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int DEPTH      = FETCH_DEPTH,
  parameter int RESET_PC   = FETCH_RESET_PC
) (
  input  logic                  clock,
  input  logic                  nreset,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0] mem_rsp_data,
  output logic                  inst_valid,
  output logic [WORD_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  busy
);

  localparam int CW = cnt_width(DEPTH);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redirect_base;
  logic [CW-1:0]         outstanding_q, outstanding_d, discard_q, discard_d, occupancy;
  logic [CW:0]           credit_used;
  logic                  run_q, run_d;
  logic                  req_fire, rsp_keep, push, pop, fifo_full, fifo_empty;
  entry_t                push_entry, head_entry;
  logic                  unused_redirect_lsb;

  assign redirect_base       = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // run_q keeps the request channel quiet for the first cycle after reset.
  assign credit_used   = {1'b0, occupancy} + {1'b0, outstanding_q};
  assign mem_req_valid = nreset && run_q && !redirect_valid && !fifo_full &&
                         (credit_used < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign rsp_keep   = mem_rsp_valid && (discard_q == '0);
  assign push       = rsp_keep && !redirect_valid;
  assign push_entry = '{data: mem_rsp_data, pc: rsp_pc_q};

  assign inst_valid = !fifo_empty;
  assign inst_data  = head_entry.data;
  assign inst_pc    = head_entry.pc;
  assign pop        = inst_valid && inst_ready;
  assign busy       = (outstanding_q != '0) || !fifo_empty;

  always_comb begin
    run_d         = 1'b1;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(mem_rsp_valid);
    discard_d     = discard_q;
    if (mem_rsp_valid && (discard_q != '0)) discard_d = discard_q - 1'b1;
    if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
    if (push)     rsp_pc_d   = rsp_pc_q + ADDR_WIDTH'(4);
    // Everything still in flight after this cycle belongs to the old stream.
    if (redirect_valid) begin
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= ADDR_WIDTH'(RESET_PC);
      rsp_pc_q      <= ADDR_WIDTH'(RESET_PC);
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      run_q         <= run_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_WIDTH + ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock     (clock),
    .nreset    (nreset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .flush     (redirect_valid),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised bench for fetch_prefetch_unit against an in-order instruction-stream model and a latency memory.
module tb_fetch_prefetch_unit;

  localparam int WW = 32;
  localparam int AW = 14;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RPC = '0;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          mem_req_valid, mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [WW-1:0] mem_rsp_data = '0;
  logic          inst_valid, inst_ready = 1'b0;
  logic [WW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          busy;

  always #5 clock = ~clock;

  fetch_prefetch_unit #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clock(clock), .nreset(nreset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat = 1;

  typedef struct { int due; logic [AW-1:0] addr; } pend_t;
  pend_t pend[$];

  // Reference model: next PC expected on the request bus and at decode.
  logic [AW-1:0] m_req_pc = RPC, m_inst_pc = RPC;
  logic [AW-1:0] e_req_addr, e_inst_pc;
  logic          s_rst, s_redir, s_req_vld, s_req_fire, s_inst_vld, s_pop, s_busy;
  logic [AW-1:0] s_req_addr, s_inst_pc;
  logic [WW-1:0] s_inst_dat;

  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    return WW'(a);
  endfunction

  // Sample one cycle at the falling edge, advance the model and the memory, then drive the next response.
  task automatic step();
    @(negedge clock);
    s_rst      = !nreset;
    s_redir    = redirect_valid;
    s_req_vld  = mem_req_valid;
    s_req_addr = mem_req_addr;
    s_req_fire = mem_req_valid && mem_req_ready;
    s_inst_vld = inst_valid;
    s_inst_dat = inst_data;
    s_inst_pc  = inst_pc;
    s_pop      = inst_valid && inst_ready;
    s_busy     = busy;
    e_req_addr = m_req_pc;
    e_inst_pc  = m_inst_pc;
    if (s_rst) begin
      pend.delete();
      m_req_pc  = RPC;
      m_inst_pc = RPC;
    end else begin
      if (s_req_fire) begin
        pend.push_back('{cyc + lat, mem_req_addr});
        m_req_pc = m_req_pc + AW'(4);
      end
      if (s_pop) m_inst_pc = m_inst_pc + AW'(4);
      if (s_redir) begin
        m_req_pc  = {redirect_pc[AW-1:2], 2'b00};
        m_inst_pc = {redirect_pc[AW-1:2], 2'b00};
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    redirect_valid = 1'b0;
    mem_req_ready = 1'b0;
    inst_ready = 1'b0;
    step();
    step();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    vectors++;
    if (s_req_vld !== 1'b0 || s_inst_vld !== 1'b0 || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b inst=%b busy=%b expected 0 0 0", s_req_vld, s_inst_vld, s_busy);
    end
    mem_req_ready = 1'b1;
    step();
    vectors++;
    if (s_req_vld !== 1'b1 || s_req_addr !== RPC) begin
      miscompares++;
      $display("FAIL reset_first_req: got valid=%b addr=%h expected 1 %h", s_req_vld, s_req_addr, RPC);
    end
  endtask

  task automatic test_basic();
    int first = -1;
    do_reset();
    lat = 1;
    mem_req_ready = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (first >= 0) begin
        vectors++;
        if (s_inst_vld !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_sustain: cycle %0d got inst_valid=%b expected 1", i, s_inst_vld);
        end
      end
      if (s_inst_vld && first < 0) first = i;
      if (s_pop) begin
        vectors++;
        if (s_inst_pc !== e_inst_pc || s_inst_dat !== mem_word(e_inst_pc)) begin
          miscompares++;
          $display("FAIL basic_pop: got pc=%h data=%h expected pc=%h data=%h", s_inst_pc, s_inst_dat, e_inst_pc, mem_word(e_inst_pc));
        end
      end
    end
    vectors++;
    if (first != 3) begin
      miscompares++;
      $display("FAIL basic_latency: got first inst_valid at cycle %0d expected 3", first);
    end
  endtask

  task automatic test_backpressure();
    int fires = 0;
    int pops = 0;
    do_reset();
    lat = 1;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_req_fire) fires++;
    end
    vectors++;
    if (fires != DEPTH || s_req_vld !== 1'b0 || s_inst_vld !== 1'b1 || s_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_credit: got fires=%0d req=%b inst=%b busy=%b expected %0d 0 1 1", fires, s_req_vld, s_inst_vld, s_busy, DEPTH);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_req_fire) begin
        vectors++;
        if (s_req_addr !== e_req_addr) begin
          miscompares++;
          $display("FAIL stall_req_addr: got %h expected %h", s_req_addr, e_req_addr);
        end
      end
      if (s_pop) begin
        pops++;
        vectors++;
        if (s_inst_pc !== e_inst_pc || s_inst_dat !== mem_word(e_inst_pc)) begin
          miscompares++;
          $display("FAIL stall_pop: got pc=%h data=%h expected pc=%h", s_inst_pc, s_inst_dat, e_inst_pc);
        end
      end
    end
    vectors++;
    if (pops < 10) begin
      miscompares++;
      $display("FAIL stall_drain: got %0d pops expected at least 10", pops);
    end
  endtask

  task automatic test_random_ready();
    logic          pending = 1'b0;
    logic [AW-1:0] held = '0;
    int            pops = 0;
    do_reset();
    lat = 3;
    for (int i = 0; i < 200; i++) begin
      mem_req_ready = 1'($urandom_range(0, 1));
      inst_ready = ($urandom_range(0, 3) != 0);
      step();
      if (pending && s_req_vld) begin
        vectors++;
        if (s_req_addr !== held) begin
          miscompares++;
          $display("FAIL rand_addr_stable: got %h expected %h", s_req_addr, held);
        end
      end
      pending = s_req_vld && !s_req_fire;
      held = s_req_addr;
      if (s_req_fire) begin
        vectors++;
        if (s_req_addr !== e_req_addr) begin
          miscompares++;
          $display("FAIL rand_req_addr: got %h expected %h", s_req_addr, e_req_addr);
        end
      end
      if (s_pop) begin
        pops++;
        vectors++;
        if (s_inst_pc !== e_inst_pc || s_inst_dat !== mem_word(e_inst_pc)) begin
          miscompares++;
          $display("FAIL rand_pop: got pc=%h data=%h expected pc=%h", s_inst_pc, s_inst_dat, e_inst_pc);
        end
      end
    end
    vectors++;
    if (pops < 20) begin
      miscompares++;
      $display("FAIL rand_progress: got %0d pops expected at least 20", pops);
    end
  endtask

  task automatic test_redirect();
    logic [AW-1:0] targets [3];
    logic [AW-1:0] want0 [3];
    logic [AW-1:0] want1 [3];
    int            fires = 0;
    logic [AW-1:0] got [$];
    targets[0] = 14'h0100; want0[0] = 14'h0100; want1[0] = 14'h0104;
    targets[1] = 14'h3FFC; want0[1] = 14'h3FFC; want1[1] = 14'h0000;
    targets[2] = 14'h0102; want0[2] = 14'h0100; want1[2] = 14'h0104;
    do_reset();
    lat = 4;
    mem_req_ready = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (s_req_fire) fires++;
    end
    vectors++;
    if (fires != 3 || s_inst_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_inflight: got fires=%0d inst=%b expected 3 0", fires, s_inst_vld);
    end
    for (int t = 0; t < 3; t++) begin
      got.delete();
      redirect_valid = 1'b1;
      redirect_pc = targets[t];
      step();
      redirect_valid = 1'b0;
      vectors++;
      if (s_req_vld !== 1'b0) begin
        miscompares++;
        $display("FAIL redir_req_quiet: got mem_req_valid=%b expected 0", s_req_vld);
      end
      for (int i = 0; i < 30; i++) begin
        step();
        if (s_pop) begin
          got.push_back(s_inst_pc);
          vectors++;
          if (s_inst_pc !== e_inst_pc || s_inst_dat !== mem_word(e_inst_pc)) begin
            miscompares++;
            $display("FAIL redir_pop: got pc=%h data=%h expected pc=%h", s_inst_pc, s_inst_dat, e_inst_pc);
          end
        end
      end
      vectors++;
      if (got.size() < 2 || got[0] !== want0[t] || got[1] !== want1[t]) begin
        miscompares++;
        $display("FAIL redir_target_%0d: got %0d pops first=%h second=%h expected %h %h", t, got.size(),
                 (got.size() > 0) ? got[0] : 14'h0, (got.size() > 1) ? got[1] : 14'h0, want0[t], want1[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 2;
    for (int i = 0; i < 300; i++) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready = 1'($urandom_range(0, 1));
      redirect_valid = (i < 260) && ($urandom_range(0, 5) == 0);
      redirect_pc = AW'($urandom);
      step();
      if (s_redir) begin
        vectors++;
        if (s_req_vld !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_req_quiet: got mem_req_valid=%b expected 0", s_req_vld);
        end
      end
      if (s_req_fire) begin
        vectors++;
        if (s_req_addr !== e_req_addr) begin
          miscompares++;
          $display("FAIL b2b_req_addr: got %h expected %h", s_req_addr, e_req_addr);
        end
      end
      if (s_pop) begin
        vectors++;
        if (s_inst_pc !== e_inst_pc || s_inst_dat !== mem_word(e_inst_pc)) begin
          miscompares++;
          $display("FAIL b2b_pop: got pc=%h data=%h expected pc=%h", s_inst_pc, s_inst_dat, e_inst_pc);
        end
      end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    int fires = 0;
    do_reset();
    lat = 3;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (s_req_fire) fires++;
    end
    vectors++;
    if (fires != DEPTH || s_inst_vld !== 1'b1 || s_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mrst_setup: got fires=%0d inst=%b busy=%b expected %0d 1 1", fires, s_inst_vld, s_busy, DEPTH);
    end
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    step();
    vectors++;
    if (s_inst_vld !== 1'b0 || s_req_vld !== 1'b0 || s_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mrst_clear: got inst=%b req=%b busy=%b expected 0 0 0", s_inst_vld, s_req_vld, s_busy);
    end
    inst_ready = 1'b1;
    fires = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_req_fire) begin
        vectors++;
        if (s_req_addr !== e_req_addr || (fires == 0 && s_req_addr !== RPC)) begin
          miscompares++;
          $display("FAIL mrst_req_addr: got %h expected %h", s_req_addr, (fires == 0) ? RPC : e_req_addr);
        end
        fires++;
      end
      if (s_pop) begin
        vectors++;
        if (s_inst_pc !== e_inst_pc || s_inst_dat !== mem_word(e_inst_pc)) begin
          miscompares++;
          $display("FAIL mrst_pop: got pc=%h data=%h expected pc=%h", s_inst_pc, s_inst_dat, e_inst_pc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random_ready();
    test_redirect();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
